mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage and the MEM stage of the in-order pipeline. It grants one transaction at a time to a fixed-latency, non-pipelined memory and gives data accesses priority, with a bounded-burst fairness rule so fetch is never starved. It generates the fetch-stage `PC_stall`, the fetch valid flag and the MEM-stage stall. Taken branches squash in-flight fetches.

## Interface
- `LATENCY`, 2: cycles from command issue to response, ≥1.
- `MAX_DATA_BURST`, 4: maximum consecutive data grants while a fetch is waiting, ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch wants an instruction; held until served or a branch redirects.
- `if_addr`  in  32  fetch address; bits [1:0] are ignored.
- `ex_take_branch_out`  in  1  taken branch; squashes any in-flight fetch.
- `mem_req`  in  1  MEM-stage access request; held until `mem_done`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `proc2mem_command`  out  2  NONE/LOAD/STORE to memory.
- `proc2mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b0}`.
- `proc2mem_data`  out  32  store data; 0 when not storing.
- `mem2proc_data`  in  32  memory read data, valid exactly `LATENCY` cycles after the command.
- `if_IR`  out  32  fetched instruction.
- `if_valid_inst`  out  1  `if_IR` valid this cycle.
- `PC_stall`  out  1  hold the PC.
- `mem_rdata`  out  32  load data.
- `mem_done`  out  1  data transaction completes this cycle.
- `mem_stall`  out  1  `mem_req & ~mem_done`.

## Operation
- States are IDLE and BUSY. BUSY carries `owner` (IF/MEM), a countdown `cnt`, and a `squash` flag.
- A grant is possible in IDLE, or in the BUSY response cycle (`cnt==0`), which allows back-to-back issue. Memory accepts at most one outstanding command.
- Grant priority:
  - `mem_req` wins, unless `if_req` is high and `streak==MAX_DATA_BURST`; then fetch wins.
  - Otherwise `if_req` wins.
  - No fetch grant is made in a cycle with `ex_take_branch_out=1`, because the address is stale.
- On a grant in cycle T, the arbiter drives `proc2mem_*` combinationally that cycle and sets `cnt <= LATENCY-1`, `owner`, and `squash <= 0`.
- `cnt` decrements every BUSY cycle. The response cycle is T+`LATENCY`, when `cnt==0`.
- `streak` counter:
  - Increments on a data grant while `if_req=1`, saturating at `MAX_DATA_BURST`.
  - Clears on a fetch grant, or in any cycle where `if_req=0`.
- Squash: `ex_take_branch_out=1` while `owner==IF` and the fetch is not yet in its response cycle sets `squash`. A branch in the response cycle itself also suppresses delivery.
- Fetch response cycle:
  - `if_IR = mem2proc_data`.
  - `if_valid_inst = ~squash & ~ex_take_branch_out`.
- Data response cycle: `mem_done=1` for both loads and stores, `mem_rdata = mem2proc_data` (0 for stores).
- `PC_stall = ~if_valid_inst`. The PC advances only on a delivered fetch; the branch path overrides the stall externally.
- No grant and not BUSY means `proc2mem_command = NONE` and the arbiter stays IDLE.

## Timing
- Reset (async assert, `rst=0`):
  - State IDLE, `cnt=0`, `streak=0`, `squash=0`.
  - Outputs: `proc2mem_command=NONE`, addr/data 0, `if_valid_inst=0`, `mem_done=0`, `PC_stall=1`, `mem_stall=mem_req`.
  - Reset mid-transaction abandons it; the memory response is ignored.
  - Deassertion is synchronized externally.
- Latency:
  - A request presented to an idle arbiter completes at T+`LATENCY`.
  - Sustained throughput is one transaction per `LATENCY` cycles.
- Simultaneous `if_req` and `mem_req` from IDLE: data first, fetch granted in the data response cycle.
- Request inputs are not sampled after the grant; address and data are captured in the grant cycle only.

## Structure
- Shared package `mem_arb_pkg`:
  - `mem_cmd_t` enum: `BUS_NONE=2'd0`, `BUS_LOAD=2'd1`, `BUS_STORE=2'd2`, shared with the memory model.
  - `arb_state_t` enum: IDLE, BUSY.
  - `arb_owner_t` enum: IF, MEM.
- One module; no sub-module needed. The countdown is a local `$clog2(LATENCY+1)`-bit register.

## Test plan
- Reset → `PC_stall=1`, `proc2mem_command=NONE`. Then `if_req=1`, `if_addr=0x0` (`LATENCY=2`) → LOAD @0x0 at T, `if_valid_inst=1` at T+2 with the memory word, `PC_stall=0` only at T+2.
- `if_req` and `mem_req` (load @0x100) together from IDLE → data granted at T, `mem_done` at T+2, fetch command issued at T+2, `if_valid_inst` at T+4.
- Continuous stores with `if_req` held (`MAX_DATA_BURST=4`) → 4 STOREs, then 1 LOAD fetch, then stores resume; fetch is never delayed more than 4 data grants.
- Fetch issued at T, `ex_take_branch_out` pulsed at T+1 → response at T+2 has `if_valid_inst=0`; no fetch grant is made in the branch cycle.
- `rst` asserted at T+1 of a data load → all outputs return to reset values immediately, `mem_done` never pulses, and a new request after release is served normally.
- `LATENCY=1`, alternating requests → back-to-back issue every cycle, each response exactly 1 cycle after its command.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter and the memory model behind it.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } mem_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    IF  = 1'b0,
    MEM = 1'b1
  } arb_owner_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and MEM stage: data priority with a
// bounded data burst, fixed-latency non-pipelined memory, branch squash of fetches.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        ex_take_branch_out,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output mem_cmd_t    proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic [31:0] mem2proc_data,
  output logic [31:0] if_IR,
  output logic        if_valid_inst,
  output logic        PC_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          squash_q, squash_d;
  logic          we_q, we_d;

  logic resp, can_grant, fetch_first, grant_if, grant_mem;

  assign resp        = (state_q == BUSY) && (cnt_q == '0);
  // Gating with rst keeps the bus quiet while reset is held, even with requests up.
  assign can_grant   = rst && ((state_q == IDLE) || resp);
  assign fetch_first = if_req && (streak_q == STREAK_MAX);
  assign grant_if    = can_grant && if_req && !ex_take_branch_out && (!mem_req || fetch_first);
  assign grant_mem   = can_grant && mem_req && !grant_if;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= IF;
      cnt_q    <= '0;
      streak_q <= '0;
      squash_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      squash_q <= squash_d;
      we_q     <= we_d;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    squash_d = squash_q;
    we_d     = we_q;
    streak_d = streak_q;

    if (grant_if || grant_mem) begin
      state_d  = BUSY;
      owner_d  = grant_if ? IF : MEM;
      cnt_d    = CNT_INIT;
      squash_d = 1'b0;
      we_d     = grant_mem && mem_we;
    end else if (resp) begin
      state_d  = IDLE;
      squash_d = 1'b0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_ONE;
      if (owner_q == IF && ex_take_branch_out) squash_d = 1'b1;
    end

    if (!if_req || grant_if) begin
      streak_d = '0;
    end else if (grant_mem && streak_q != STREAK_MAX) begin
      streak_d = streak_q + STREAK_ONE;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if_IR            = '0;
    if_valid_inst    = 1'b0;
    mem_rdata        = '0;
    mem_done         = 1'b0;

    if (grant_if) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = word_align(if_addr);
    end else if (grant_mem) begin
      proc2mem_command = mem_we ? BUS_STORE : BUS_LOAD;
      proc2mem_addr    = word_align(mem_addr);
      proc2mem_data    = mem_we ? mem_wdata : '0;
    end

    if (resp && owner_q == IF) begin
      if_IR         = mem2proc_data;
      if_valid_inst = ~squash_q & ~ex_take_branch_out;
    end
    if (resp && owner_q == MEM) begin
      mem_done  = 1'b1;
      mem_rdata = we_q ? '0 : mem2proc_data;
    end
  end

  assign PC_stall  = ~if_valid_inst;
  assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LATENCY=2 instance for the main scenarios
// and one LATENCY=1 instance for back-to-back alternation.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- LATENCY=2 instance ----------------
  logic        if_req, ex_br, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, mem2proc_data;
  mem_cmd_t    p_cmd;
  logic [31:0] p_addr, p_data, if_IR, mem_rdata;
  logic        if_valid, pc_stall, mem_done, mem_stall;

  mem_arbiter #(.LATENCY(2), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .ex_take_branch_out(ex_br),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .mem2proc_data(mem2proc_data),
    .if_IR(if_IR), .if_valid_inst(if_valid), .PC_stall(pc_stall),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall)
  );

  // ---------------- LATENCY=1 instance ----------------
  logic        if_req1, ex_br1, mem_req1, mem_we1;
  logic [31:0] if_addr1, mem_addr1, mem_wdata1, mem2proc_data1;
  mem_cmd_t    p_cmd1;
  logic [31:0] p_addr1, p_data1, if_IR1, mem_rdata1;
  logic        if_valid1, pc_stall1, mem_done1, mem_stall1;

  mem_arbiter #(.LATENCY(1), .MAX_DATA_BURST(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .ex_take_branch_out(ex_br1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .proc2mem_command(p_cmd1), .proc2mem_addr(p_addr1), .proc2mem_data(p_data1),
    .mem2proc_data(mem2proc_data1),
    .if_IR(if_IR1), .if_valid_inst(if_valid1), .PC_stall(pc_stall1),
    .mem_rdata(mem_rdata1), .mem_done(mem_done1), .mem_stall(mem_stall1)
  );

  // Memory model: a load returns word_of(addr) exactly LATENCY cycles later.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  mem_cmd_t    c0 = BUS_NONE, c1 = BUS_NONE, c0_1 = BUS_NONE;
  logic [31:0] a0 = '0, a1 = '0, a0_1 = '0;
  always @(posedge clk) begin
    c0   <= p_cmd;  a0   <= p_addr;
    c1   <= c0;     a1   <= a0;
    c0_1 <= p_cmd1; a0_1 <= p_addr1;
  end
  assign mem2proc_data  = (c1 == BUS_LOAD)   ? word_of(a1)   : 32'hDEAD_BEEF;
  assign mem2proc_data1 = (c0_1 == BUS_LOAD) ? word_of(a0_1) : 32'hDEAD_BEEF;

  logic [65:0] bus, bus1;
  logic [3:0]  flags, flags1;
  assign bus    = {p_cmd, p_addr, p_data};
  assign bus1   = {p_cmd1, p_addr1, p_data1};
  assign flags  = {if_valid, pc_stall, mem_done, mem_stall};
  assign flags1 = {if_valid1, pc_stall1, mem_done1, mem_stall1};

  logic [65:0] eb;
  logic [33:0] er;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; ex_br = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    if_req1 = 0; ex_br1 = 0; mem_req1 = 0; mem_we1 = 0;
    if_addr1 = '0; mem_addr1 = '0; mem_wdata1 = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    if_req = 1; mem_req = 1; if_addr = 32'h10; mem_addr = 32'h20;
    sample();
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL reset_bus: got %h want %h", bus, eb); end
    checks++; if (flags !== 4'b0101) begin failures++; $display("FAIL reset_flags: got %b want %b", flags, 4'b0101); end
    checks++; if (bus1 !== eb) begin failures++; $display("FAIL reset_bus_l1: got %h want %h", bus1, eb); end
    tick();
    clear_inputs();
    rst = 1;
  endtask

  task automatic test_fetch();
    tick(); if_req = 1; if_addr = 32'h0; sample();
    eb = {BUS_LOAD, 32'h0, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL fetch_issue: got %h want %h", bus, eb); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL fetch_issue_flags: got %b want %b", flags, 4'b0100); end
    tick(); sample();
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL fetch_wait_bus: got %h want %h", bus, eb); end
    checks++; if (pc_stall !== 1'b1) begin failures++; $display("FAIL fetch_wait_stall: got %b want 1", pc_stall); end
    tick(); sample();
    er = {1'b1, 1'b0, word_of(32'h0)};
    checks++; if ({if_valid, pc_stall, if_IR} !== er) begin failures++; $display("FAIL fetch_resp: got %h want %h", {if_valid, pc_stall, if_IR}, er); end
    eb = {BUS_LOAD, 32'h0, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL fetch_b2b_issue: got %h want %h", bus, eb); end
    tick(); if_req = 0; sample();
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL fetch_gap_flags: got %b want %b", flags, 4'b0100); end
    tick(); sample();
    er = {1'b1, 1'b0, word_of(32'h0)};
    checks++; if ({if_valid, pc_stall, if_IR} !== er) begin failures++; $display("FAIL fetch_b2b_resp: got %h want %h", {if_valid, pc_stall, if_IR}, er); end
    tick(); sample();
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if (bus !== eb || flags !== 4'b0100) begin failures++; $display("FAIL fetch_idle: got %h/%b want %h/%b", bus, flags, eb, 4'b0100); end
  endtask

  task automatic test_priority();
    tick(); if_req = 1; if_addr = 32'h40; mem_req = 1; mem_we = 0; mem_addr = 32'h102; sample();
    eb = {BUS_LOAD, 32'h100, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL prio_data_first: got %h want %h", bus, eb); end
    tick(); sample();
    checks++; if (flags !== 4'b0101) begin failures++; $display("FAIL prio_wait_flags: got %b want %b", flags, 4'b0101); end
    tick(); mem_req = 0; sample();
    er = {1'b1, 1'b0, word_of(32'h100)};
    checks++; if ({mem_done, mem_stall, mem_rdata} !== er) begin failures++; $display("FAIL prio_data_resp: got %h want %h", {mem_done, mem_stall, mem_rdata}, er); end
    eb = {BUS_LOAD, 32'h40, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL prio_fetch_issue: got %h want %h", bus, eb); end
    tick(); sample();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL prio_fetch_early: got %b want 0", if_valid); end
    tick(); if_req = 0; sample();
    er = {1'b1, 1'b0, word_of(32'h40)};
    checks++; if ({if_valid, pc_stall, if_IR} !== er) begin failures++; $display("FAIL prio_fetch_resp: got %h want %h", {if_valid, pc_stall, if_IR}, er); end
    tick(); clear_inputs();
  endtask

  task automatic test_burst();
    for (int n = 0; n <= 12; n++) begin
      tick();
      if (n == 0) begin if_req = 1; if_addr = 32'h80; mem_req = 1; mem_we = 1; end
      if (n % 2 == 0) begin mem_addr = 32'h200 + 32'(4 * (n / 2)); mem_wdata = 32'h1000 + 32'(n / 2); end
      if (n == 10) if_req = 0;
      if (n == 12) mem_req = 0;
      sample();
      if (n % 2 == 1 || n == 12) eb = {BUS_NONE, 32'h0, 32'h0};
      else if (n == 8) eb = {BUS_LOAD, 32'h80, 32'h0};
      else eb = {BUS_STORE, 32'h200 + 32'(4 * (n / 2)), 32'h1000 + 32'(n / 2)};
      checks++; if (bus !== eb) begin failures++; $display("FAIL burst_bus[%0d]: got %h want %h", n, bus, eb); end
      if (n % 2 == 0 && n >= 2) begin
        if (n == 10) er = {1'b1, 1'b0, word_of(32'h80)};
        else er = {1'b0, 1'b1, 32'h0};
        checks++;
        if ({if_valid, mem_done, (n == 10) ? if_IR : mem_rdata} !== er) begin
          failures++;
          $display("FAIL burst_resp[%0d]: got %h want %h", n, {if_valid, mem_done, (n == 10) ? if_IR : mem_rdata}, er);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    tick(); if_req = 1; if_addr = 32'h300; sample();
    eb = {BUS_LOAD, 32'h300, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL br_issue: got %h want %h", bus, eb); end
    tick(); ex_br = 1; if_addr = 32'h403; sample();
    tick(); ex_br = 0; sample();
    checks++; if ({if_valid, pc_stall} !== 2'b01) begin failures++; $display("FAIL br_squash: got %b want %b", {if_valid, pc_stall}, 2'b01); end
    eb = {BUS_LOAD, 32'h400, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL br_target_issue: got %h want %h", bus, eb); end
    tick(); sample();
    tick(); if_req = 0; sample();
    er = {1'b1, 1'b0, word_of(32'h400)};
    checks++; if ({if_valid, pc_stall, if_IR} !== er) begin failures++; $display("FAIL br_target_resp: got %h want %h", {if_valid, pc_stall, if_IR}, er); end
    tick(); if_req = 1; ex_br = 1; if_addr = 32'h500; sample();
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL br_no_grant_idle: got %h want %h", bus, eb); end
    tick(); ex_br = 0; sample();
    eb = {BUS_LOAD, 32'h500, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL br_issue2: got %h want %h", bus, eb); end
    tick(); sample();
    tick(); ex_br = 1; if_addr = 32'h600; sample();
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if ({if_valid, pc_stall} !== 2'b01 || bus !== eb) begin failures++; $display("FAIL br_in_resp: got %b/%h want %b/%h", {if_valid, pc_stall}, bus, 2'b01, eb); end
    tick(); ex_br = 0; sample();
    eb = {BUS_LOAD, 32'h600, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL br_issue3: got %h want %h", bus, eb); end
    tick(); sample();
    tick(); if_req = 0; sample();
    er = {1'b1, 1'b0, word_of(32'h600)};
    checks++; if ({if_valid, pc_stall, if_IR} !== er) begin failures++; $display("FAIL br_resp3: got %h want %h", {if_valid, pc_stall, if_IR}, er); end
    tick(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    tick(); mem_req = 1; mem_we = 0; mem_addr = 32'h700; sample();
    eb = {BUS_LOAD, 32'h700, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL rstmid_issue: got %h want %h", bus, eb); end
    tick(); rst = 0; #1;
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if (bus !== eb || flags !== 4'b0101) begin failures++; $display("FAIL rstmid_assert: got %h/%b want %h/%b", bus, flags, eb, 4'b0101); end
    tick(); sample();
    checks++; if (flags !== 4'b0101) begin failures++; $display("FAIL rstmid_no_done: got %b want %b", flags, 4'b0101); end
    tick(); rst = 1; sample();
    eb = {BUS_LOAD, 32'h700, 32'h0};
    checks++; if (bus !== eb) begin failures++; $display("FAIL rstmid_reissue: got %h want %h", bus, eb); end
    tick(); sample();
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL rstmid_early_done: got %b want 0", mem_done); end
    tick(); mem_req = 0; sample();
    er = {1'b1, 1'b0, word_of(32'h700)};
    checks++; if ({mem_done, mem_stall, mem_rdata} !== er) begin failures++; $display("FAIL rstmid_resp: got %h want %h", {mem_done, mem_stall, mem_rdata}, er); end
    tick(); clear_inputs();
  endtask

  task automatic test_back_to_back_l1();
    tick(); if_req1 = 1; if_addr1 = 32'h800; mem_req1 = 1; mem_we1 = 0; mem_addr1 = 32'h900; sample();
    eb = {BUS_LOAD, 32'h900, 32'h0};
    checks++; if (bus1 !== eb) begin failures++; $display("FAIL l1_c0_bus: got %h want %h", bus1, eb); end
    tick(); mem_req1 = 0; sample();
    eb = {BUS_LOAD, 32'h800, 32'h0};
    checks++; if (bus1 !== eb) begin failures++; $display("FAIL l1_c1_bus: got %h want %h", bus1, eb); end
    er = {1'b1, 1'b0, word_of(32'h900)};
    checks++; if ({mem_done1, if_valid1, mem_rdata1} !== er) begin failures++; $display("FAIL l1_c1_resp: got %h want %h", {mem_done1, if_valid1, mem_rdata1}, er); end
    tick(); mem_req1 = 1; mem_addr1 = 32'h904; if_addr1 = 32'h804; sample();
    eb = {BUS_LOAD, 32'h904, 32'h0};
    checks++; if (bus1 !== eb) begin failures++; $display("FAIL l1_c2_bus: got %h want %h", bus1, eb); end
    er = {1'b1, 1'b0, word_of(32'h800)};
    checks++; if ({if_valid1, mem_done1, if_IR1} !== er) begin failures++; $display("FAIL l1_c2_resp: got %h want %h", {if_valid1, mem_done1, if_IR1}, er); end
    tick(); mem_req1 = 0; sample();
    eb = {BUS_LOAD, 32'h804, 32'h0};
    checks++; if (bus1 !== eb) begin failures++; $display("FAIL l1_c3_bus: got %h want %h", bus1, eb); end
    er = {1'b1, 1'b0, word_of(32'h904)};
    checks++; if ({mem_done1, if_valid1, mem_rdata1} !== er) begin failures++; $display("FAIL l1_c3_resp: got %h want %h", {mem_done1, if_valid1, mem_rdata1}, er); end
    tick(); if_req1 = 0; sample();
    eb = {BUS_NONE, 32'h0, 32'h0};
    checks++; if (bus1 !== eb) begin failures++; $display("FAIL l1_c4_bus: got %h want %h", bus1, eb); end
    er = {1'b1, 1'b0, word_of(32'h804)};
    checks++; if ({if_valid1, pc_stall1, if_IR1} !== er) begin failures++; $display("FAIL l1_c4_resp: got %h want %h", {if_valid1, pc_stall1, if_IR1}, er); end
    tick(); sample();
    checks++; if (flags1 !== 4'b0100) begin failures++; $display("FAIL l1_idle_flags: got %b want %b", flags1, 4'b0100); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_burst();
    test_branch();
    test_reset_mid();
    test_back_to_back_l1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
